alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
Execute stage that sits directly downstream of reg_file and upstream of its write port. Consumes the two read operands (RD1/RD2) and the destination address. Produces the registered ALUResult together with a one-cycle write strobe and the write address back into reg_file. Single-cycle ops finish in 1 cycle; MUL is an iterative shift-add that takes WIDTH cycles, with busy/done handshake to the control path.

Parameters:
WIDTH, 8, operand/result width (matches register file data width)
ADDR_W, 4, register address width (matches reg_file WA)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on the rising edge only when not busy
op  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
a  input  WIDTH  operand A (from RD1)
b  input  WIDTH  operand B (from RD2); for shifts, b[2:0] is the shift amount
wa_in  input  ADDR_W  destination register for this operation
busy  output  1  high while a MUL is iterating
done  output  1  one-cycle pulse: result valid
write_enable  output  1  equals done; drives reg_file write_enable
wa_out  output  ADDR_W  destination captured at accept; held
alu_result  output  WIDTH  result (MUL: low half); held until next completion
mul_hi  output  WIDTH  MUL high half; 0 after non-MUL ops
zero  output  1  alu_result == 0; updated with done
carry  output  1  carry/borrow/shift-out/overflow flag; updated with done

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE. busy, done, write_enable, carry and zero=0. alu_result, mul_hi, wa_out and internal registers=0. Takes effect immediately, regardless of clk.
- States: IDLE, MUL. Operation is accepted when start=1 at a rising edge in IDLE. wa_in is captured at the accept edge.
- Non-MUL op accepted at edge T0: alu_result, flags, mul_hi=0, wa_out and done=1 all update at T0 (1-cycle latency). Stays in IDLE.
- ADD: result=(a+b) mod 2^WIDTH; carry=carry-out.
- SUB: result=(a-b) mod 2^WIDTH; carry=1 iff a<b (borrow).
- AND/OR/XOR: bitwise; carry=0.
- SHL/SHR: logical shift by b[2:0]; carry=last bit shifted out; carry=0 when amount is 0.
- MUL accepted at T0: load multiplicand (zero-extended to 2*WIDTH), multiplier, acc=0, cnt=0; busy=1 from T0; state->MUL.
  - Each edge in MUL: if multiplier[0], add multiplicand to acc; shift multiplicand left 1; shift multiplier right 1; cnt++.
  - On the WIDTH-th iteration edge (T0+WIDTH): alu_result=product[WIDTH-1:0], mul_hi=product[2*WIDTH-1:WIDTH], carry=(mul_hi!=0), done=1, busy=0, state->IDLE.
  - Product is unsigned, full 2*WIDTH bits.
- zero always reflects the new alu_result (low half for MUL).
- done/write_enable: high exactly one cycle after each completion; otherwise 0.
- start while busy is ignored: no capture, no effect on the in-flight MUL or on wa_out.
- A start during the cycle done is high (state IDLE) is accepted: back-to-back operation at full rate.
- Outputs alu_result, mul_hi, flags and wa_out hold their values between completions.
- Reset mid-MUL aborts the operation: no done is ever issued for it, and all outputs return to reset values.
- No output changes combinationally from inputs; all outputs are registered.

Test Plan:
1. Reset, then ADD a=200 b=100 wa_in=3 -> next edge: alu_result=44, carry=1, zero=0, done=write_enable=1 for exactly 1 cycle, wa_out=3, busy stays 0.
2. SUB a=5 b=5 -> alu_result=0, zero=1, carry=0. Then SUB a=3 b=5 -> alu_result=254, carry=1.
3. SHL a=0x81 b=1 -> alu_result=0x02, carry=1. SHR a=0x81 b=0 -> alu_result=0x81, carry=0.
4. MUL a=13 b=15 wa_in=5 -> busy=1 for 8 cycles; start with ADD and wa_in=9 at cycle 3 ignored; done at T0+8 with alu_result=195, mul_hi=0, carry=0, wa_out=5.
5. MUL a=20 b=20 -> alu_result=144, mul_hi=1, carry=1. ADD 1+1 started in the done cycle -> alu_result=2, mul_hi=0, done one cycle later.
6. MUL a=255 b=255, rst_n low at cycle 4 asynchronously -> busy=0 and all outputs 0 immediately; no done pulse afterwards. After release, ADD 1+2 -> alu_result=3.

Source files
------------

// File: rtl/alu_unit.sv
// Execute-stage ALU between reg_file read ports and its write port.
// Single-cycle logic/arith ops; MUL is an iterative shift-add taking WIDTH cycles.
module alu_unit #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [ADDR_W-1:0] wa_in,
    output logic              busy,
    output logic              done,
    output logic              write_enable,
    output logic [ADDR_W-1:0] wa_out,
    output logic [WIDTH-1:0]  alu_result,
    output logic [WIDTH-1:0]  mul_hi,
    output logic              zero,
    output logic              carry
);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
                           OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t                 r_state, w_next;
    logic [2*WIDTH-1:0]     r_mcand, r_acc, w_acc_nxt;
    logic [WIDTH-1:0]       r_mplier;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_done, r_zero, r_carry;
    logic [WIDTH-1:0]       r_result, r_mul_hi;
    logic [ADDR_W-1:0]      r_wa;
    logic                   w_accept, w_mul_last;
    logic [WIDTH-1:0]       w_res;
    logic                   w_cy;
    logic [WIDTH:0]         w_add, w_sub, w_shl, w_shr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start && op == OP_MUL)          w_next = S_MUL;
            S_MUL:  if (r_cnt == CNT_W'(WIDTH - 1))      w_next = S_IDLE;
            default:                                     w_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_accept   = (r_state == S_IDLE) && start;
        w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_W'(WIDTH - 1));
        busy       = (r_state == S_MUL);
    end

    // Carry/borrow live in the extra top bit; shift-out lands in the spare end bit
    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} - {1'b0, b};
    assign w_shl = {1'b0, a} << b[2:0];
    assign w_shr = {a, 1'b0} >> b[2:0];

    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        case (op)
            OP_ADD: begin w_res = w_add[WIDTH-1:0]; w_cy = w_add[WIDTH]; end
            OP_SUB: begin w_res = w_sub[WIDTH-1:0]; w_cy = w_sub[WIDTH]; end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_SHL: begin w_res = w_shl[WIDTH-1:0]; w_cy = w_shl[WIDTH]; end
            OP_SHR: begin w_res = w_shr[WIDTH:1];   w_cy = w_shr[0];     end
            default: ;
        endcase
    end

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_mul_hi <= '0;
            r_wa     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_wa <= wa_in;
                if (op == OP_MUL) begin
                    r_mcand  <= {{WIDTH{1'b0}}, a};
                    r_mplier <= b;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end else begin
                    r_result <= w_res;
                    r_carry  <= w_cy;
                    r_zero   <= (w_res == '0);
                    r_mul_hi <= '0;
                    r_done   <= 1'b1;
                end
            end
            if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_mul_last) begin
                    r_result <= w_acc_nxt[WIDTH-1:0];
                    r_mul_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
                    r_carry  <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                    r_zero   <= (w_acc_nxt[WIDTH-1:0] == '0);
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign done         = r_done;
    assign write_enable = r_done;
    assign wa_out       = r_wa;
    assign alu_result   = r_result;
    assign mul_hi       = r_mul_hi;
    assign zero         = r_zero;
    assign carry        = r_carry;
endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: single-cycle ops, iterative MUL, busy-drop and async abort.
module tb_alu_unit;
    localparam int W = 8, AW = 4;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [2:0]    op = '0;
    logic [W-1:0]  a = '0, b = '0;
    logic [AW-1:0] wa_in = '0;
    logic          busy, done, write_enable, zero, carry;
    logic [AW-1:0] wa_out;
    logic [W-1:0]  alu_result, mul_hi;

    int checks = 0, errors = 0;
    int seen_done;

    alu_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .wa_in(wa_in),
        .busy(busy), .done(done), .write_enable(write_enable), .wa_out(wa_out),
        .alu_result(alu_result), .mul_hi(mul_hi), .zero(zero), .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a request and let one rising edge sample it; returns at edge+1.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [AW-1:0] w);
        start = 1'b1; op = o; a = x; b = y; wa_in = w;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_res", alu_result, 0);  chk("rst_wa", wa_out, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: ADD with carry-out
        issue(3'b000, 8'd200, 8'd100, 4'd3);
        chk("add_res", alu_result, 44); chk("add_cy", carry, 1);  chk("add_z", zero, 0);
        chk("add_done", done, 1);       chk("add_we", write_enable, 1);
        chk("add_wa", wa_out, 3);       chk("add_busy", busy, 0);
        @(posedge clk); #1;
        chk("add_done_pulse", done, 0); chk("add_hold", alu_result, 44);

        // 2: SUB zero and borrow
        issue(3'b001, 8'd5, 8'd5, 4'd1);
        chk("sub0_res", alu_result, 0); chk("sub0_z", zero, 1); chk("sub0_cy", carry, 0);
        issue(3'b001, 8'd3, 8'd5, 4'd1);
        chk("subb_res", alu_result, 254); chk("subb_cy", carry, 1); chk("subb_z", zero, 0);

        // 3: shifts and logic
        issue(3'b101, 8'h81, 8'd1, 4'd2);
        chk("shl_res", alu_result, 8'h02); chk("shl_cy", carry, 1);
        issue(3'b110, 8'h81, 8'd0, 4'd2);
        chk("shr0_res", alu_result, 8'h81); chk("shr0_cy", carry, 0);
        issue(3'b110, 8'h81, 8'd1, 4'd2);
        chk("shr1_res", alu_result, 8'h40); chk("shr1_cy", carry, 1);
        issue(3'b010, 8'hF0, 8'h3C, 4'd2); chk("and_res", alu_result, 8'h30);
        issue(3'b011, 8'hF0, 8'h3C, 4'd2); chk("or_res", alu_result, 8'hFC);
        issue(3'b100, 8'hF0, 8'h3C, 4'd2); chk("xor_res", alu_result, 8'hCC);
        chk("xor_cy", carry, 0);

        // 4: MUL 13*15, with a start during busy that must be ignored
        issue(3'b111, 8'd13, 8'd15, 4'd5);
        chk("mul_busy0", busy, 1); chk("mul_done0", done, 0);
        for (int k = 1; k <= 7; k++) begin
            if (k == 3) begin start = 1'b1; op = 3'b000; a = 8'd1; b = 8'd1; wa_in = 4'd9; end
            @(posedge clk); #1;
            start = 1'b0;
            chk($sformatf("mul_busy%0d", k), {busy, done}, 2'b10);
        end
        @(posedge clk); #1;
        chk("mul_done", done, 1); chk("mul_busy_end", busy, 0);
        chk("mul_res", alu_result, 195); chk("mul_hi", mul_hi, 0);
        chk("mul_cy", carry, 0); chk("mul_wa", wa_out, 5);

        // 5: MUL with high half, then ADD accepted in the done cycle
        issue(3'b111, 8'd20, 8'd20, 4'd6);
        repeat (7) begin @(posedge clk); #1; end
        chk("mul2_early", done, 0);
        @(posedge clk); #1;
        chk("mul2_done", done, 1); chk("mul2_res", alu_result, 144);
        chk("mul2_hi", mul_hi, 1); chk("mul2_cy", carry, 1);
        issue(3'b000, 8'd1, 8'd1, 4'd7);
        chk("b2b_done", done, 1); chk("b2b_res", alu_result, 2);
        chk("b2b_hi", mul_hi, 0); chk("b2b_wa", wa_out, 7);

        // 6: async reset aborts an in-flight MUL
        issue(3'b111, 8'd255, 8'd255, 4'd8);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0); chk("abort_res", alu_result, 0);
        chk("abort_hi", mul_hi, 0); chk("abort_wa", wa_out, 0);
        chk("abort_flags", {done, carry, zero}, 0);
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin @(posedge clk); #1; if (done) seen_done++; end
        chk("abort_no_done", seen_done, 0);
        issue(3'b000, 8'd1, 8'd2, 4'd4);
        chk("post_res", alu_result, 3); chk("post_done", done, 1); chk("post_wa", wa_out, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
